// File: rtl/add_sub_pipe.sv
// Pipelined WIDTH-bit adder/subtractor with the carry chain cut into SEG-bit
// segments, one register stage per segment, and valid/ready on both sides.
module add_sub_pipe #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = (WIDTH / SEG < 1) ? 1 : WIDTH / SEG;
  localparam int LAST   = STAGES - 1;

  if ((SEG < 1) || (WIDTH % SEG != 0)) begin : g_bad_params
    $error("add_sub_pipe: WIDTH must be a non-zero multiple of SEG");
  end

  logic             v_q [STAGES];
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] r_q [STAGES];
  logic             c_q [STAGES];
  logic             ovf_q;

  logic             v_x [STAGES];
  logic [WIDTH-1:0] a_x [STAGES];
  logic [WIDTH-1:0] b_x [STAGES];
  logic [WIDTH-1:0] r_x [STAGES];
  logic             c_x [STAGES];

  logic [WIDTH-1:0] r_n [STAGES];
  logic             c_n [STAGES];
  logic             ovf_n;
  logic [SEG:0]     seg_tot;
  logic             en;

  assign en       = ~v_q[LAST] | out_ready;
  assign in_ready = en;

  // Stage 1 sees the ports with b and cin already inverted for subtraction;
  // later stages see the registers of the stage before them.
  assign v_x[0] = in_valid;
  assign a_x[0] = a;
  assign b_x[0] = sub ? ~b : b;
  assign c_x[0] = cin ^ sub;
  assign r_x[0] = '0;

  for (genvar k = 1; k < STAGES; k++) begin : g_link
    assign v_x[k] = v_q[k-1];
    assign a_x[k] = a_q[k-1];
    assign b_x[k] = b_q[k-1];
    assign c_x[k] = c_q[k-1];
    assign r_x[k] = r_q[k-1];
  end

  // Each stage fills in its own result segment and passes its carry onward.
  always_comb begin
    seg_tot = '0;
    for (int k = 0; k < STAGES; k++) begin
      r_n[k]  = r_x[k];
      seg_tot = {1'b0, a_x[k][k*SEG +: SEG]} + {1'b0, b_x[k][k*SEG +: SEG]}
              + {{SEG{1'b0}}, c_x[k]};
      r_n[k][k*SEG +: SEG] = seg_tot[SEG-1:0];
      c_n[k]  = seg_tot[SEG];
    end
    ovf_n = a_x[LAST][WIDTH-1] ^ b_x[LAST][WIDTH-1] ^ r_n[LAST][WIDTH-1] ^ c_n[LAST];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        r_q[k] <= '0;
        c_q[k] <= 1'b0;
      end
      ovf_q <= 1'b0;
    end else if (en) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= v_x[k];
        a_q[k] <= a_x[k];
        b_q[k] <= b_x[k];
        r_q[k] <= r_n[k];
        c_q[k] <= c_n[k];
      end
      ovf_q <= ovf_n;
    end
  end

  assign out_valid = v_q[LAST];
  assign sum       = r_q[LAST];
  assign cout      = c_q[LAST];
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_add_sub_pipe.sv
// Bench for add_sub_pipe: directed corner cases, back-pressure, reset mid-stream
// and random traffic against an arithmetic reference model.
module tb_add_sub_pipe;

  localparam int WIDTH = 16;
  localparam int SEG   = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int stall_cnt = 0;

  typedef struct {
    logic [17:0] res;
    int          acc;
    int          snap;
  } exp_t;
  exp_t q[$];

  logic        held = 1'b0;
  logic [17:0] held_val;

  always #5 clk = ~clk;

  add_sub_pipe #(.WIDTH(WIDTH), .SEG(SEG)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
  );

  // Reference: {cout, sum, ovf} from plain integer arithmetic.
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic ci, input logic sb);
    int unsigned tot;
    int sx, sy, ideal;
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (sb) begin
      tot   = int'(x) + (32'hFFFF - int'(y)) + (ci ? 0 : 1);
      ideal = sx - sy - int'(ci);
    end else begin
      tot   = int'(x) + int'(y) + int'(ci);
      ideal = sx + sy + int'(ci);
    end
    return {tot[16], tot[15:0], (ideal > 32767) || (ideal < -32768)};
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_fail++;
    $display("[TB] FAIL %s: got timeout, required event (t=%0t)", name, $time);
  endtask

  always @(posedge clk) cyc++;

  always @(negedge rst_n) begin
    q.delete();
    held = 1'b0;
  end

  // Single compare process: handshake rule, hold stability, ordered results, latency.
  always @(negedge clk) begin
    if (rst_n) begin
      check_output("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
      if (held) begin
        check_output("hold_valid", 32'(out_valid), 32'd1);
        check_output("hold_data", 32'({cout, sum, ovf}), 32'(held_val));
      end
      held     = out_valid && !out_ready;
      held_val = {cout, sum, ovf};
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check_output("unexpected_result", 32'(out_valid), 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check_output("result", 32'({cout, sum, ovf}), 32'(e.res));
          check_output("latency", 32'(cyc - e.acc - (stall_cnt - e.snap)), 32'd3);
        end
      end
      if (out_valid && !out_ready) stall_cnt++;
      if (in_valid && in_ready) begin
        exp_t n;
        n.res  = model(a, b, cin, sub);
        n.acc  = cyc + 1;
        n.snap = stall_cnt;
        q.push_back(n);
      end
    end
  end

  // Present one operand set and return just after the edge that accepts it.
  task automatic apply_stimulus(input logic [15:0] x, input logic [15:0] y,
                                input logic ci, input logic sb);
    int w;
    a = x; b = y; cin = ci; sub = sb; in_valid = 1'b1;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      w++;
      @(negedge clk);
    end
    if (w >= 50) timeout_fail("accept_wait");
    @(posedge clk); #1;
  endtask

  task automatic directed(input string name, input logic [15:0] x, input logic [15:0] y,
                          input logic ci, input logic sb, input logic [17:0] req);
    apply_stimulus(x, y, ci, sb);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_output({name, "_early"}, 32'(out_valid), 32'd0);
    @(posedge clk);
    #1 check_output({name, "_valid"}, 32'(out_valid), 32'd1);
    check_output({name, "_data"}, 32'({cout, sum, ovf}), 32'(req));
    @(posedge clk);
    #1 check_output({name, "_one_cycle"}, 32'(out_valid), 32'd0);
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (q.size() != 0 && w < 40) begin
      w++;
      @(posedge clk);
    end
    #1 check_output("drained", 32'(q.size()), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got time limit, required $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] corners [4];
    corners[0] = 16'h0000; corners[1] = 16'hFFFF;
    corners[2] = 16'h7FFF; corners[3] = 16'h8000;

    check_output("model_add_wrap", 32'(model(16'hFFFF, 16'h0001, 1'b0, 1'b0)), 32'({1'b1, 16'h0000, 1'b0}));
    check_output("model_add_ovf",  32'(model(16'h7FFF, 16'h0001, 1'b0, 1'b0)), 32'({1'b0, 16'h8000, 1'b1}));
    check_output("model_sub_neg",  32'(model(16'h0005, 16'h0007, 1'b0, 1'b1)), 32'({1'b0, 16'hFFFE, 1'b0}));
    check_output("model_sub_ovf",  32'(model(16'h8000, 16'h0000, 1'b1, 1'b1)), 32'({1'b1, 16'h7FFF, 1'b1}));

    #2;
    check_output("reset_outputs", 32'({out_valid, sum, cout, ovf}), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check_output("ready_after_reset", 32'(in_ready), 32'd1);

    directed("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b1, 16'h0000, 1'b0});
    directed("add_ovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b0, 16'h8000, 1'b1});
    directed("sub_neg",  16'h0005, 16'h0007, 1'b0, 1'b1, {1'b0, 16'hFFFE, 1'b0});
    directed("sub_ovf",  16'h8000, 16'h0000, 1'b1, 1'b1, {1'b1, 16'h7FFF, 1'b1});

    $display("[TB] back-pressure");
    fork
      begin
        for (int i = 0; i < 6; i++)
          apply_stimulus(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        in_valid = 1'b0;
      end
      begin
        int w;
        w = 0;
        while (!out_valid && w < 30) begin
          w++;
          @(posedge clk); #1;
        end
        if (w >= 30) timeout_fail("first_result_wait");
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
          #1 check_output("stall_in_ready", 32'(in_ready), 32'd0);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();

    $display("[TB] reset mid-stream");
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) apply_stimulus(16'($urandom), 16'($urandom), 1'b0, 1'b0);
    in_valid = 1'b0;
    begin
      int w;
      w = 0;
      while (!out_valid && w < 30) begin
        w++;
        @(posedge clk); #1;
      end
      if (w >= 30) timeout_fail("fill_wait");
    end
    check_output("pipe_full", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_output("async_clear", 32'(out_valid), 32'd0);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1 check_output("no_stale", 32'(out_valid), 32'd0);
    end

    $display("[TB] random traffic");
    for (int i = 0; i < 200; i++) begin
      logic [15:0] x, y;
      x = ($urandom_range(0, 4) == 0) ? corners[$urandom_range(0, 3)] : 16'($urandom);
      y = ($urandom_range(0, 4) == 0) ? corners[$urandom_range(0, 3)] : 16'($urandom);
      apply_stimulus(x, y, 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
